// File: rtl/arbitro_barramento_snoop.sv
// Round-robin arbiter and sequencer for the shared snooping bus.
// Broadcasts the granted CPU's word and, for read misses, relays one snoop reply or a default reply.
module arbitro_barramento_snoop #(
    parameter int unsigned NUM_CPU       = 3,
    parameter int unsigned BUS_W         = 11,
    parameter int unsigned SNOOP_TIMEOUT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CPU-1:0]         req,
    input  logic [NUM_CPU*BUS_W-1:0]   msg_in,
    input  logic [NUM_CPU-1:0]         snoop_valid,
    output logic [NUM_CPU-1:0]         grant,
    output logic [BUS_W-1:0]           bus_out,
    output logic                       bus_valid,
    output logic                       busy
);
    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = $clog2(SNOOP_TIMEOUT + 1);
    localparam logic [1:0]  OP_READ_MISS = 2'b00;
    localparam logic [1:0]  OP_EMPTY     = 2'b11;

    typedef enum logic [2:0] {IDLE, GRANT, BCAST, SNOOP, RESP, DONE} state_t;

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    granted_id;
    logic [BUS_W-1:0]   cmd_reg;
    logic [BUS_W-1:0]   rsp_reg;
    logic [CNT_W-1:0]   counter;

    logic [BUS_W-1:0]   words [NUM_CPU];
    logic [BUS_W-1:0]   sel_word;
    logic [BUS_W-1:0]   hit_word;
    logic               snoop_hit;
    logic [NUM_CPU-1:0] rr_onehot;
    logic [ID_W-1:0]    rr_id;
    logic               rr_found;
    int unsigned        idx;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CPU; i++) begin
            words[i] = msg_in[i*BUS_W +: BUS_W];
        end
    end

    // Search starts just after the last granted CPU and wraps around.
    always_comb begin
        rr_found  = 1'b0;
        rr_id     = '0;
        rr_onehot = '0;
        idx       = 0;
        for (int unsigned off = 1; off <= NUM_CPU; off++) begin
            idx = 32'(last_grant) + off;
            if (idx >= NUM_CPU) idx = idx - NUM_CPU;
            if (!rr_found && req[idx]) begin
                rr_found       = 1'b1;
                rr_id          = ID_W'(idx);
                rr_onehot[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_word  = '0;
        hit_word  = '0;
        snoop_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_CPU; i++) begin
            if (ID_W'(i) == granted_id) sel_word = words[i];
            if (!snoop_hit && snoop_valid[i] && (ID_W'(i) != granted_id) &&
                words[i][10] && (words[i][5:4] == OP_EMPTY)) begin
                snoop_hit = 1'b1;
                hit_word  = words[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            bus_out    <= '0;
            bus_valid  <= 1'b0;
            busy       <= 1'b0;
            last_grant <= ID_W'(NUM_CPU - 1);
            granted_id <= '0;
            cmd_reg    <= '0;
            rsp_reg    <= '0;
            counter    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        grant      <= rr_onehot;
                        granted_id <= rr_id;
                        busy       <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    cmd_reg      <= sel_word;
                    cmd_reg[9:8] <= granted_id;
                    state        <= BCAST;
                end
                BCAST: begin
                    bus_out   <= cmd_reg;
                    bus_valid <= 1'b1;
                    counter   <= '0;
                    state     <= (cmd_reg[5:4] == OP_READ_MISS) ? SNOOP : DONE;
                end
                SNOOP: begin
                    bus_valid <= 1'b0;
                    // A real reply wins even on the cycle the timeout expires.
                    if (snoop_hit) begin
                        rsp_reg      <= hit_word;
                        rsp_reg[9:8] <= granted_id;
                        state        <= RESP;
                    end else if (counter == CNT_W'(SNOOP_TIMEOUT - 1)) begin
                        rsp_reg <= {1'b0, granted_id, 2'b00, OP_EMPTY, cmd_reg[3], 3'b000};
                        state   <= RESP;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                RESP: begin
                    bus_out   <= rsp_reg;
                    bus_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    grant      <= '0;
                    bus_out    <= '0;
                    bus_valid  <= 1'b0;
                    busy       <= 1'b0;
                    last_grant <= granted_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arbitro_barramento_snoop.sv
// Bench for the snooping bus arbiter: directed scenarios then random transactions
// checked cycle by cycle against a transaction-level reference model.
module tb_arbitro_barramento_snoop;
    localparam int unsigned NUM_CPU       = 3;
    localparam int unsigned BUS_W         = 11;
    localparam int unsigned SNOOP_TIMEOUT = 4;
    localparam int unsigned MW            = NUM_CPU * BUS_W;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_CPU-1:0] req = '0;
    logic [MW-1:0]      msg_in = '0;
    logic [NUM_CPU-1:0] snoop_valid = '0;
    logic [NUM_CPU-1:0] grant;
    logic [BUS_W-1:0]   bus_out;
    logic               bus_valid;
    logic               busy;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          txn_no   = 0;
    int unsigned m_last;

    arbitro_barramento_snoop #(
        .NUM_CPU(NUM_CPU),
        .BUS_W(BUS_W),
        .SNOOP_TIMEOUT(SNOOP_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .msg_in(msg_in),
        .snoop_valid(snoop_valid),
        .grant(grant),
        .bus_out(bus_out),
        .bus_valid(bus_valid),
        .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned pick(input int unsigned last, input logic [NUM_CPU-1:0] rq);
        int unsigned c;
        for (int unsigned off = 1; off <= NUM_CPU; off++) begin
            c = (last + off) % NUM_CPU;
            if (rq[c]) return c;
        end
        return 0;
    endfunction

    function automatic logic [BUS_W-1:0] word_of(input logic [MW-1:0] v, input int unsigned i);
        return v[i*BUS_W +: BUS_W];
    endfunction

    // One whole transaction: predict winner, broadcast word, reply and length, then walk it.
    task automatic do_txn(input logic [NUM_CPU-1:0] rq, input logic [MW-1:0] cmds,
                          input int rsp_at, input logic [NUM_CPU-1:0] rmask,
                          input logic [MW-1:0] rwords, input bit drop, input bit noise);
        int unsigned      id;
        logic [BUS_W-1:0] exp_cmd, exp_rsp, w;
        bit               is_rm, hit;
        int               s, total;
        logic [31:0]      exp_grant;
        id = pick(m_last, rq);
        exp_cmd = word_of(cmds, id);
        exp_cmd[9:8] = 2'(id);
        is_rm = (exp_cmd[5:4] == 2'b00);
        hit = 1'b0;
        s = int'(SNOOP_TIMEOUT) - 1;
        exp_rsp = {1'b0, 2'(id), 2'b00, 2'b11, exp_cmd[3], 3'b000};
        if (is_rm && rsp_at >= 0 && rsp_at < int'(SNOOP_TIMEOUT)) begin
            for (int unsigned i = 0; i < NUM_CPU; i++) begin
                w = word_of(rwords, i);
                if (!hit && rmask[i] && i != id && w[10] && w[5:4] == 2'b11) begin
                    hit = 1'b1;
                    s = rsp_at;
                    exp_rsp = w;
                    exp_rsp[9:8] = 2'(id);
                end
            end
        end
        total = is_rm ? 6 + s : 4;
        req = rq;
        msg_in = cmds;
        snoop_valid = '0;
        for (int k = 0; k < total; k++) begin
            @(posedge clock);
            #1;
            exp_grant = (k < total - 1) ? (32'(1) << id) : 32'(0);
            check($sformatf("t%0d k%0d grant", txn_no, k), 32'(grant), exp_grant);
            check($sformatf("t%0d k%0d busy", txn_no, k), 32'(busy), 32'(k < total - 1));
            check($sformatf("t%0d k%0d bus_valid", txn_no, k), 32'(bus_valid),
                  32'((k == 2) || (is_rm && k == total - 2)));
            if (k == 2)
                check($sformatf("t%0d k%0d bus_out_cmd", txn_no, k), 32'(bus_out), 32'(exp_cmd));
            else if (is_rm && k == total - 2)
                check($sformatf("t%0d k%0d bus_out_rsp", txn_no, k), 32'(bus_out), 32'(exp_rsp));
            else if (k < 2 || k == total - 1)
                check($sformatf("t%0d k%0d bus_out_zero", txn_no, k), 32'(bus_out), 32'(0));
            if (k == 1) begin
                if (drop) req = '0;
                if (noise) begin
                    snoop_valid = rmask;
                    msg_in = rwords;
                end
            end else if (k >= 2) begin
                snoop_valid = (k - 2 == rsp_at) ? rmask : '0;
                msg_in = rwords;
            end
        end
        req = '0;
        snoop_valid = '0;
        m_last = id;
        txn_no++;
    endtask

    localparam logic [BUS_W-1:0] INV = 11'b0_00_0_0_10_0_011;
    localparam logic [BUS_W-1:0] RM1 = 11'b0_00_0_0_00_1_000;
    localparam logic [BUS_W-1:0] RM0 = 11'b0_11_0_0_00_0_101;

    initial begin
        logic [MW-1:0]      cmds, rw;
        logic [BUS_W-1:0]   w;
        logic [NUM_CPU-1:0] rq;
        int unsigned        r;

        // Reset values while reset is held and just after release.
        repeat (2) @(posedge clock);
        #1;
        check("rst grant", 32'(grant), 32'(0));
        check("rst bus_valid", 32'(bus_valid), 32'(0));
        check("rst busy", 32'(busy), 32'(0));
        check("rst bus_out", 32'(bus_out), 32'(0));
        reset = 1'b0;
        m_last = NUM_CPU - 1;
        @(posedge clock);
        #1;
        check("idle busy", 32'(busy), 32'(0));

        // Round-robin with all three requesting: 0,1,2,0.
        for (int n = 0; n < 4; n++) do_txn(3'b111, {INV, INV, INV}, -1, '0, '0, 1'b0, 1'b0);

        // Reset in the middle of SNOOP.
        req = 3'b010;
        msg_in = {INV, RM1, INV};
        repeat (4) @(posedge clock);
        #1;
        check("pre-rst busy", 32'(busy), 32'(1));
        check("pre-rst grant", 32'(grant), 32'(3'b010));
        #2;
        reset = 1'b1;
        #1;
        check("midrst grant", 32'(grant), 32'(0));
        check("midrst bus_valid", 32'(bus_valid), 32'(0));
        check("midrst busy", 32'(busy), 32'(0));
        check("midrst bus_out", 32'(bus_out), 32'(0));
        @(negedge clock);
        reset = 1'b0;
        req = '0;
        m_last = NUM_CPU - 1;
        do_txn(3'b001, {INV, INV, INV}, -1, '0, '0, 1'b0, 1'b0);

        // Read-miss hit: CPU0 misses with tag 1, CPU2 answers in the second SNOOP cycle.
        do_txn(3'b001, {INV, INV, RM1}, 1, 3'b100, {11'b10000111101, 22'b0}, 1'b0, 1'b0);
        // Timeout: CPU1 misses, nobody answers.
        do_txn(3'b010, {INV, RM1, INV}, -1, '0, '0, 1'b0, 1'b0);
        // Collision: all reply at once, CPU0 wins, CPU1 (requester) ignored.
        rw = {11'b1_10_0_0_11_1_001, 11'b1_01_0_0_11_1_111, 11'b1_00_0_0_11_0_110};
        do_txn(3'b010, {INV, RM0, INV}, 0, 3'b111, rw, 1'b0, 1'b0);
        do_txn(3'b010, {INV, RM0, INV}, 0, 3'b110, rw, 1'b0, 1'b0);
        // Non-empty op or shared=0 replies are not accepted.
        do_txn(3'b100, {RM1, INV, INV}, 0, 3'b011,
               {11'b1_00_0_0_11_1_111, 11'b0_00_0_0_11_1_010, 11'b1_00_0_0_10_1_001}, 1'b0, 1'b0);
        // Reply in the very cycle the timeout expires.
        do_txn(3'b001, {INV, INV, RM1}, int'(SNOOP_TIMEOUT) - 1, 3'b010,
               {11'b0, 11'b1_00_1_1_11_0_100, 11'b0}, 1'b0, 1'b0);
        // Replies during BCAST are ignored; the miss times out.
        do_txn(3'b010, {INV, RM0, INV}, -1, 3'b101, rw, 1'b0, 1'b1);
        // Request dropped during BCAST; then the same lone requester is re-granted.
        do_txn(3'b100, {INV, INV, INV}, -1, '0, '0, 1'b1, 1'b0);
        do_txn(3'b100, {RM1, INV, INV}, 2, 3'b001, rw, 1'b1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rq = 3'($urandom_range(1, 7));
            for (int unsigned i = 0; i < NUM_CPU; i++) begin
                w = 11'($urandom);
                r = $urandom_range(0, 3);
                w[5:4] = (r < 2) ? 2'b00 : 2'($urandom);
                cmds[i*BUS_W +: BUS_W] = w;
                w = 11'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    w[10] = 1'b1;
                    w[5:4] = 2'b11;
                end
                rw[i*BUS_W +: BUS_W] = w;
            end
            do_txn(rq, cmds, int'($urandom_range(0, SNOOP_TIMEOUT)), 3'($urandom_range(0, 7)),
                   rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
